// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Optional build macro MULDIV_FAST_PATH_EN: divide-by-zero and signed-overflow divides bypass the iteration.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic            done
);

  localparam int CNT_W = $clog2(XLEN);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIN
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic              bzero_q, bzero_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_hi;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [XLEN-1:0]   acc_hi, acc_lo;
  logic [XLEN-1:0]   prod_hi_fix, quo_fix, rem_fix;

`ifdef MULDIV_FAST_PATH_EN
  logic              div_ovf;
  assign div_ovf = ((funct3 == OP_DIV) || (funct3 == OP_REM)) &&
                   (opA == {1'b1, {(XLEN-1){1'b0}}}) && (opB == {XLEN{1'b1}});
`endif

  // NOTE: every signal written in this block gets a value before any branch, so no latches are inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    bzero_d  = bzero_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    done_d   = 1'b0;

    // Operand conditioning: magnitudes for the signed operand positions of the requested op.
    a_neg = opA[XLEN-1] & ((funct3 == OP_MULH) || (funct3 == OP_MULHSU) ||
                           (funct3 == OP_DIV)  || (funct3 == OP_REM));
    b_neg = opB[XLEN-1] & ((funct3 == OP_MULH) || (funct3 == OP_DIV) || (funct3 == OP_REM));
    a_mag = a_neg ? -opA : opA;
    b_mag = b_neg ? -opB : opB;

    acc_hi = acc_q[2*XLEN-1:XLEN];
    acc_lo = acc_q[XLEN-1:0];

    mul_sum  = {1'b0, acc_hi} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_hi   = acc_q[2*XLEN-1:XLEN-1];
    div_ge   = (div_hi >= {1'b0, b_q});
    div_diff = div_hi[XLEN-1:0] - b_q;

    // High word of the negated 64-bit product: ~hi plus the carry out of -lo.
    prod_hi_fix = neg_q ? (~acc_hi + ((acc_lo == '0) ? XLEN'(1) : XLEN'(0))) : acc_hi;
    quo_fix     = neg_q ? -acc_lo : acc_lo;
    rem_fix     = neg_q ? -acc_hi : acc_hi;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = funct3;
          cnt_d   = '0;
          neg_d   = a_neg ^ (b_neg & (funct3 != OP_REM));
          bzero_d = (opB == '0);
          b_d     = b_mag;
          acc_d   = {{XLEN{1'b0}}, a_mag};
          state_d = S_CALC;
`ifdef MULDIV_FAST_PATH_EN
          if (funct3[2] && ((opB == '0) || div_ovf)) begin
            acc_d   = (opB == '0) ? {a_mag, {XLEN{1'b1}}} : {{XLEN{1'b0}}, a_mag};
            state_d = S_FIN;
          end
`endif
        end
      end

      S_CALC: begin
        if (op_q[2]) begin
          acc_d = div_ge ? {div_diff, acc_q[XLEN-2:0], 1'b1}
                         : {div_hi[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(XLEN-1)) state_d = S_FIN;
      end

      S_FIN: begin
        unique case (op_q)
          OP_MUL:                       result_d = acc_lo;
          OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_hi_fix;
          OP_DIV, OP_DIVU:              result_d = bzero_q ? {XLEN{1'b1}} : quo_fix;
          default:                      result_d = rem_fix;
        endcase
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // busy stays up through the done cycle so it falls together with done.
    busy_d = (state_d != S_IDLE) || (state_q == S_FIN);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      bzero_q  <= 1'b0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      bzero_q  <= bzero_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, random ops against a behavioural model,
// back-to-back accept, mid-operation reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] opA, opB;
  logic [31:0] result;
  logic        busy, done;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  localparam int LAT_FULL = 34;
`ifdef MULDIV_FAST_PATH_EN
  localparam int LAT_CORNER = 2;
`else
  localparam int LAT_CORNER = 34;
`endif

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          corner;
    string       name;
  } vec_t;

  vec_t vecs[16];

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .opA    (opA),
    .opB    (opB),
    .result (result),
    .busy   (busy),
    .done   (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFFFFFF; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  // Called right after the accept edge has been sampled; lat counts cycles from the start cycle.
  task automatic wait_done(input string name, input int exp_lat);
    int lat;
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (done !== 1'b1) begin
      check({name, "_timeout"}, {31'b0, done}, 32'd1);
    end else begin
      check({name, "_latency"}, 32'(lat), 32'(exp_lat));
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL %s_scoreboard: done with no expected result queued", name);
      end else begin
        check(name, result, exp_q.pop_front());
      end
      @(posedge clk); #1;
      check({name, "_done_width"}, {31'b0, done}, 32'd0);
      check({name, "_busy_drop"}, {31'b0, busy}, 32'd0);
    end
  endtask

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expv, input int exp_lat, input string name);
    @(negedge clk);
    start  = 1'b1;
    funct3 = f;
    opA    = a;
    opB    = b;
    exp_q.push_back(expv);
    @(posedge clk); #1;
    start  = 1'b0;
    funct3 = 3'($urandom);
    opA    = $urandom;
    opB    = $urandom;
    check({name, "_busy"}, {31'b0, busy}, 32'd1);
    wait_done(name, exp_lat);
  endtask

  initial begin
    int lat;
    int spurious;
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    bit          rc;

    vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, "mul_7_m3"};
    vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, "mulh_min_min"};
    vecs[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, "mulhu_max"};
    vecs[3]  = '{3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0, "mulhsu_m1_2"};
    vecs[4]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, "mulh_m1_m1"};
    vecs[5]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, "div_m7_2"};
    vecs[6]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, "rem_m7_2"};
    vecs[7]  = '{3'b101, 32'd100,      32'd7,        32'd14,       1'b0, "divu_100_7"};
    vecs[8]  = '{3'b111, 32'd100,      32'd7,        32'd2,        1'b0, "remu_100_7"};
    vecs[9]  = '{3'b101, 32'h1234,     32'd0,        32'hFFFFFFFF, 1'b1, "divu_by0"};
    vecs[10] = '{3'b110, 32'h1234,     32'd0,        32'h00001234, 1'b1, "rem_by0"};
    vecs[11] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, "div_ovf"};
    vecs[12] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1, "rem_ovf"};
    vecs[13] = '{3'b100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1'b1, "div_neg_by0"};
    vecs[14] = '{3'b111, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1'b1, "remu_by0"};
    vecs[15] = '{3'b100, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0, "div_100_m7"};

    rst = 1'b1; start = 1'b0; funct3 = '0; opA = '0; opB = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", result, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++)
      do_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp,
            vecs[i].corner ? LAT_CORNER : LAT_FULL, vecs[i].name);

    for (int i = 0; i < 8; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : $urandom;
      rc = rf[2] && ((rb == 0) || (!rf[0] && ra == 32'h80000000 && rb == 32'hFFFFFFFF));
      do_op(rf, ra, rb, ref_op(rf, ra, rb), rc ? LAT_CORNER : LAT_FULL, $sformatf("rand_%0d", i));
    end

    // start held high with operands churning: only the first op is accepted until done.
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; opA = 32'd3; opB = 32'd5;
    exp_q.push_back(32'd15);
    @(posedge clk); #1;
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      funct3 = 3'($urandom); opA = $urandom; opB = $urandom;
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_first_latency", 32'(lat), 32'(LAT_FULL));
    check("b2b_first", result, exp_q.pop_front());
    funct3 = 3'b101; opA = 32'd100; opB = 32'd7;
    exp_q.push_back(32'd14);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_reaccept_busy", {31'b0, busy}, 32'd1);
    check("b2b_reaccept_done", {31'b0, done}, 32'd0);
    wait_done("b2b_second", LAT_FULL);

    // Reset in the middle of CALC discards the operation.
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; opA = 32'h1234; opB = 32'h10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_done", {31'b0, done}, 32'd0);
    check("rst_mid_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) spurious++;
    end
    check("rst_no_done", 32'(spurious), 32'd0);
    do_op(3'b000, 32'd3, 32'd5, 32'd15, LAT_FULL, "mul_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit sitting directly downstream of the register file: it consumes the two read-port operands (data1/data2) and returns a 32-bit result that the writeback mux selects as dataW. It executes all eight RV32M operations over multiple cycles. It exposes a busy/done handshake so the single-cycle core can hold PC and suppress regWEn until the result is ready.

## Interface
- XLEN, 32: operand/result width; only 32 is supported.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- opA  input  32  rs1 value (register-file data1).
- opB  input  32  rs2 value (register-file data2).
- result  output  32  operation result; valid when done=1, held until next accepted start.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse marking result valid.

## Operation
- States: IDLE, CALC, FIN.
- IDLE: start=1 latches funct3 and operands, loads iteration counter with 0, goes to CALC. start=0 stays in IDLE.
- Operand prep on accept: signed ops (MULH both, MULHSU opA only, DIV/REM both) take magnitudes and record the result sign. The result sign for DIV is sign(A) xor sign(B). The result sign for REM is sign(A). MUL uses the low 32 bits, which are sign-independent.
- CALC: one radix-2 step per cycle. Multiply is shift-add into a 64-bit accumulator. Divide is restoring shift-subtract producing a 32-bit quotient and a 32-bit remainder. The counter increments each cycle. After the step with counter=31, go to FIN.
- FIN: apply sign correction (two's complement negate if the sign flag is set). Select the output:
  - MUL: low 32 bits of the product.
  - MULH/MULHSU/MULHU: high 32 bits of the product.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
  - Register the selection into result, assert done, return to IDLE.
- Required corner results, all modes:
  - Divide by zero: DIV/DIVU quotient = 0xFFFFFFFF; REM/REMU = opA.
  - Signed overflow (opA=0x80000000, opB=0xFFFFFFFF, DIV/REM): quotient = 0x80000000, remainder = 0.
- start while busy=1: ignored, with no effect on the operation in flight.
- Operands and funct3 changing after accept: no effect; internal copies are used.
- rst (any state, including mid-CALC): next state IDLE, result=0, busy=0, done=0, counter=0; the operation in flight is discarded.

## Timing
- Reset values: result=0x00000000, busy=0, done=0, state=IDLE.
- start sampled high at edge E0: busy=1 from E0.
- Normal latency: CALC occupies edges E1..E32, FIN is registered at E33, so done=1 and result is valid in the cycle after E33. busy drops to 0 at E34, together with done.
- Back-to-back: a new start is accepted at E34 at the earliest, i.e. the cycle where done is high and state is IDLE.
- done is high for exactly one cycle per accepted start. It is never asserted without a prior accepted start.
- No combinational path from inputs to outputs.

## Configuration
- MULDIV_FAST_PATH_EN defined: divide-by-zero and signed-overflow divisions skip CALC. FIN is entered at E1, and done is high in the cycle after E1. Multiplies and all other divides are unchanged.
- Not defined: these cases run the full 32 iterations, with the corner values forced in FIN. Results are identical in both builds; only latency differs.

## Test plan
- MUL opA=7, opB=0xFFFFFFFD (−3) -> result 0xFFFFFFEB; done exactly 34 cycles after start edge, 1 cycle wide.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF.
- DIV −7/2 -> 0xFFFFFFFD; REM −7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 0x1234/0 -> 0xFFFFFFFF; REM 0x1234/0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 with REM 0. Latency is 34 cycles without the macro and 2 cycles with MULDIV_FAST_PATH_EN.
- Start held high continuously with changing operands -> only the first is accepted, and the next is accepted the cycle done is high. Results match the operands latched at each accept.
- rst asserted at cycle 10 of CALC -> busy=0, done=0, result=0 next cycle. No done pulse follows. A fresh MUL 3×5 afterwards -> 15.
